// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the M stage: latches one access, stalls the pipeline
// for WAIT_CYCLES+1 cycles, then completes the access in a single non-stalled DONE cycle.
module dmem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [31:0] addrM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        misalignM
);

   localparam int unsigned IdxW     = $clog2(DEPTH);
   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {StIdle, StWait, StDone} stateE;

   stateE             stateQ, stateD;
   logic [3:0]        cntQ, cntD;
   logic [IdxW+1:0]   addrQ;
   logic [31:0]       wdataQ;
   logic              isWriteQ, isReadQ;
   logic [31:0]       mem [DEPTH];

   logic              req;
   logic              enterDone;
   logic [IdxW+1:0]   curAddr;
   logic [31:0]       curWdata;
   logic              curWrite, curRead;
   logic [IdxW-1:0]   curIdx;
   logic [31:0]       unusedAddrBits;

   assign req            = memreadM | memwriteM;
   assign unusedAddrBits = addrM;

   // A zero-wait access completes on its accept edge, so it must use the live inputs.
   always_comb begin
      if (stateQ == StIdle) begin
         curAddr  = addrM[IdxW+1:0];
         curWdata = writedataM;
         curWrite = memwriteM;
         curRead  = memreadM;
      end else begin
         curAddr  = addrQ;
         curWdata = wdataQ;
         curWrite = isWriteQ;
         curRead  = isReadQ;
      end
      curIdx = curAddr[IdxW+1:2];
   end

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      enterDone = 1'b0;
      stallM    = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (req) begin
               stallM = 1'b1;
               cntD   = WaitInit;
               if (WAIT_CYCLES == 0) begin
                  stateD    = StDone;
                  enterDone = 1'b1;
               end else begin
                  stateD = StWait;
               end
            end
         end
         StWait: begin
            stallM = 1'b1;
            cntD   = cntQ - 4'd1;
            if (cntQ == 4'd1) begin
               stateD    = StDone;
               enterDone = 1'b1;
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
      // Reset discards any pending access and never stalls the pipeline.
      if (reset) begin
         stallM    = 1'b0;
         enterDone = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= StIdle;
         cntQ      <= 4'd0;
         readdataM <= 32'd0;
         misalignM <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         misalignM <= enterDone && (curAddr[1:0] != 2'b00);
         if (enterDone && curRead && !curWrite) begin
            readdataM <= mem[curIdx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (stateQ == StIdle && req) begin
         addrQ    <= addrM[IdxW+1:0];
         wdataQ   <= writedataM;
         isWriteQ <= memwriteM;
         isReadQ  <= memreadM;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (enterDone && curWrite) begin
         mem[curIdx] <= curWdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven with directed and
// random accesses, checked against a word-array memory model and the stall-length rule.
module tb_dmem_responder;

   localparam int unsigned Depth = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread  [2];
   logic        memwrite [2];
   logic [31:0] addr     [2];
   logic [31:0] wdata    [2];
   logic [31:0] rdata    [2];
   logic        stall    [2];
   logic        misalign [2];

   logic [31:0] modelMem [2][Depth];
   logic [31:0] rdExp    [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .memreadM   (memread[0]),
      .memwriteM  (memwrite[0]),
      .addrM      (addr[0]),
      .writedataM (wdata[0]),
      .readdataM  (rdata[0]),
      .stallM     (stall[0]),
      .misalignM  (misalign[0])
   );

   dmem_responder #(.DEPTH(Depth), .WAIT_CYCLES(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .memreadM   (memread[1]),
      .memwriteM  (memwrite[1]),
      .addrM      (addr[1]),
      .writedataM (wdata[1]),
      .readdataM  (rdata[1]),
      .stallM     (stall[1]),
      .misalignM  (misalign[1])
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int waitOf(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   // One complete access: drive, count stalled cycles, check the DONE cycle and the idle after.
   task automatic doAccess(input int u, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
      int          n;
      int unsigned idx;
      idx = (a >> 2) % Depth;
      @(negedge clk);
      memread[u]  = rd;
      memwrite[u] = wr;
      addr[u]     = a;
      wdata[u]    = d;
      #1;
      n = 0;
      while (stall[u] === 1'b1 && n < 40) begin
         n++;
         @(posedge clk);
         #1;
         if (stall[u] === 1'b1) begin
            memread[u]  = 1'($urandom);
            memwrite[u] = 1'($urandom);
            addr[u]     = $urandom;
            wdata[u]    = $urandom;
         end
      end
      if (wr) modelMem[u][idx] = d;
      else if (rd) rdExp[u] = modelMem[u][idx];
      checkVal("stall_cycles", 32'(n), 32'(waitOf(u) + 1));
      checkVal("misalign_done", 32'(misalign[u]), 32'(a[1:0] != 2'b00));
      checkVal("rdata_done", rdata[u], rdExp[u]);
      memread[u]  = 1'b0;
      memwrite[u] = 1'b0;
      @(posedge clk);
      #1;
      checkVal("misalign_idle", 32'(misalign[u]), 32'd0);
      checkVal("stall_idle", 32'(stall[u]), 32'd0);
      checkVal("rdata_hold", rdata[u], rdExp[u]);
   endtask

   initial begin
      int kind;
      for (int u = 0; u < 2; u++) begin
         memread[u]  = 1'b0;
         memwrite[u] = 1'b0;
         addr[u]     = 32'd0;
         wdata[u]    = 32'd0;
         rdExp[u]    = 32'd0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      memwrite[0] = 1'b1;
      addr[0]     = 32'h10;
      #1;
      checkVal("stall_in_reset", 32'(stall[0]), 32'd0);
      @(negedge clk);
      memwrite[0] = 1'b0;
      reset       = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         checkVal("reset_rdata", rdata[u], 32'd0);
         checkVal("reset_misalign", 32'(misalign[u]), 32'd0);
         checkVal("reset_stall", 32'(stall[u]), 32'd0);
      end

      // Give every word a known value.
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < int'(Depth); i++) begin
            doAccess(u, 1'b0, 1'b1, 32'(i * 4), $urandom);
         end
      end

      doAccess(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      doAccess(0, 1'b1, 1'b0, 32'h10, 32'h0);
      checkVal("wait2_read", rdata[0], 32'hDEADBEEF);

      doAccess(1, 1'b0, 1'b1, 32'h4, 32'h12345678);
      doAccess(1, 1'b1, 1'b0, 32'h4, 32'h0);
      checkVal("wait0_read", rdata[1], 32'h12345678);

      doAccess(0, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5);
      doAccess(0, 1'b1, 1'b0, 32'h0, 32'h0);
      checkVal("wrap_read", rdata[0], 32'hA5A5A5A5);

      doAccess(0, 1'b0, 1'b1, 32'h10, 32'h11);
      doAccess(0, 1'b1, 1'b0, 32'h13, 32'h0);
      checkVal("misaligned_read", rdata[0], 32'h11);

      doAccess(0, 1'b0, 1'b1, 32'h30, 32'h77);
      doAccess(0, 1'b1, 1'b0, 32'h30, 32'h0);
      doAccess(0, 1'b1, 1'b1, 32'h8, 32'h55);
      checkVal("both_keeps_rdata", rdata[0], 32'h77);
      doAccess(0, 1'b1, 1'b0, 32'h8, 32'h0);
      checkVal("both_wrote", rdata[0], 32'h55);

      // Reset in the second wait cycle of a write must drop the write.
      doAccess(0, 1'b0, 1'b1, 32'h20, 32'h0);
      @(negedge clk);
      memwrite[0] = 1'b1;
      addr[0]     = 32'h20;
      wdata[0]    = 32'hFFFFFFFF;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkVal("stall_reset_wait", 32'(stall[0]), 32'd0);
      @(posedge clk);
      #1;
      reset       = 1'b0;
      memwrite[0] = 1'b0;
      #1;
      rdExp[0] = 32'd0;
      rdExp[1] = 32'd0;
      checkVal("abort_stall", 32'(stall[0]), 32'd0);
      checkVal("abort_rdata", rdata[0], 32'd0);
      checkVal("abort_rdata0", rdata[1], 32'd0);
      doAccess(0, 1'b1, 1'b0, 32'h20, 32'h0);
      checkVal("abort_no_write", rdata[0], 32'h0);

      // A held request produces back-to-back accesses separated by one DONE cycle.
      @(negedge clk);
      memread[0] = 1'b1;
      addr[0]    = 32'h10;
      for (int i = 0; i < 8; i++) begin
         #1;
         checkVal("b2b_stall", 32'(stall[0]), 32'((i % 4) != 3));
         @(negedge clk);
      end
      memread[0] = 1'b0;
      rdExp[0]   = modelMem[0][4];
      @(posedge clk);
      #1;
      checkVal("b2b_rdata", rdata[0], rdExp[0]);

      for (int k = 0; k < 300; k++) begin
         kind = int'($urandom_range(2, 0));
         doAccess(int'($urandom_range(1, 0)), kind != 1, kind != 0, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the internal data store; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states per access; range 0..15.
REQ-003 Port clk  input  1: single clock; every register updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port memreadM  input  1: the memory stage requests a word read.
REQ-006 Port memwriteM  input  1: the memory stage requests a word write.
REQ-007 Port addrM  input  32: byte address, driven from the ALU output of the memory stage.
REQ-008 Port writedataM  input  32: store data.
REQ-009 Port readdataM  output  32: load data returned to the pipeline.
REQ-010 Port stallM  output  1: high while an access is outstanding; the pipeline freezes the F/D/E/M registers while it is high.
REQ-011 Port misalignM  output  1: one-cycle pulse marking a completed access with addrM[1:0] != 0.

Function
REQ-012 The block SHALL contain a 3-state FSM: IDLE, WAIT, DONE.
REQ-013 In IDLE, req = memreadM | memwriteM; if req=1, the block SHALL accept the request: latch addrM, writedataM and the access type, and load the wait counter with WAIT_CYCLES.
REQ-014 On accept, the next state SHALL be WAIT when WAIT_CYCLES > 0 and DONE when WAIT_CYCLES = 0.
REQ-015 In WAIT, the counter SHALL decrement once per cycle; when the counter equals 1 at a clock edge, the next state SHALL be DONE.
REQ-016 stallM SHALL be combinational: 1 in IDLE when req=1, 1 in WAIT, and 0 in DONE and in IDLE when req=0.
REQ-017 Total stall per access SHALL be exactly WAIT_CYCLES+1 cycles; the instruction advances out of M on the DONE-cycle edge.
REQ-018 A write SHALL commit to word index latched_addr[log2(DEPTH)+1:2] on the edge that enters DONE.
REQ-019 A read SHALL load readdataM from the same index on the edge that enters DONE; readdataM SHALL then hold until the next read completes or a reset occurs.
REQ-020 The DONE -> IDLE transition SHALL be unconditional; a request present in the cycle after DONE is a new access.
REQ-021 If memreadM and memwriteM are both 1, the block SHALL perform the write only and leave readdataM unchanged.
REQ-022 Address bits above log2(DEPTH)+1 SHALL be ignored, so the address wraps modulo DEPTH words.
REQ-023 A misaligned access SHALL still access the word at addr[...:2]; misalignM SHALL be 1 only during the DONE cycle of that access.
REQ-024 Input changes during WAIT/DONE SHALL be ignored; only the latched values are used.
REQ-025 Back-to-back accesses SHALL each incur the full WAIT_CYCLES+1 stall, with one non-stalled DONE cycle between them.

Reset
REQ-026 On reset=1 at an edge, the state SHALL become IDLE, the counter 0, readdataM 0 and misalignM 0.
REQ-027 A reset during WAIT SHALL discard the pending access, with no write committed and readdataM = 0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 stallM SHALL be 0 in the reset cycle regardless of req.

Verification
REQ-030 WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> stallM high for 3 cycles per access, DONE between them, readdataM=0xDEADBEEF after the read's DONE edge.
REQ-031 WAIT_CYCLES=0: read of addr 0x4 after writing 0x12345678 -> stallM high exactly 1 cycle, readdataM=0x12345678 in the DONE cycle.
REQ-032 DEPTH=64: write 0xA5A5A5A5 to 0x100, then read 0x0 -> 0xA5A5A5A5 (wrap).
REQ-033 Read addr 0x13 after writing 0x11 to word 4 -> readdataM=0x11, misalignM pulses 1 cycle in DONE.
REQ-034 Assert reset in the 2nd WAIT cycle of a write of 0xFFFFFFFF to 0x20 (word previously 0x0) -> state IDLE, stallM=0, readdataM=0; a later read of 0x20 returns 0x0.
REQ-035 memreadM=memwriteM=1 with writedataM=0x55 at addr 0x8, readdataM previously 0x77 -> word 2 becomes 0x55, readdataM stays 0x77.
